cmpi_shared_arbiter: RTL and testbench

- Shares one unsigned less-than comparator among N dataflow requesters.
- Each requester presents an lhs/rhs pair under a valid/ready handshake.
- A round-robin arbiter grants at most one requester per cycle.
- Each requester's 1-bit result is returned through its own one-slot registered output buffer and handshake.
- Sits where several cmpi consumers are folded onto one comparator for area.

---
 rtl/cmpi_shared_arbiter.sv | 97 +++++++++
 tb/tb_cmpi_shared_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cmpi_shared_arbiter.sv
// Round-robin sharing of one less-than comparator among NUM_REQ requesters, each with a one-slot result buffer.
// Optional macro CMPI_ARB_SIGNED_EN selects a two's-complement signed compare (default build: unsigned).
module cmpi_shared_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int DATA_TYPE = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*DATA_TYPE-1:0]   ins_lhs,
    input  logic [NUM_REQ*DATA_TYPE-1:0]   ins_rhs,
    input  logic [NUM_REQ-1:0]             ins_valid,
    output logic [NUM_REQ-1:0]             ins_ready,
    output logic [NUM_REQ-1:0]             outs,
    output logic [NUM_REQ-1:0]             outs_valid,
    input  logic [NUM_REQ-1:0]             outs_ready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]        p_q, p_d;
    logic [NUM_REQ-1:0]   outs_q, outs_d;
    logic [NUM_REQ-1:0]   outs_valid_q, outs_valid_d;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic                 gnt_vld;
    logic [PW-1:0]        gnt_idx;
    logic [DATA_TYPE-1:0] lhs_g, rhs_g;
    logic                 lt;
    int                   idx;

    // A slot that drains this cycle may be refilled in the same cycle.
    assign elig = ins_valid & (~outs_valid_q | outs_ready);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(p_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_vld && !rst) gnt_oh[gnt_idx] = 1'b1;
    end

    assign ins_ready = gnt_oh;

    assign lhs_g = ins_lhs[int'(gnt_idx)*DATA_TYPE +: DATA_TYPE];
    assign rhs_g = ins_rhs[int'(gnt_idx)*DATA_TYPE +: DATA_TYPE];

`ifdef CMPI_ARB_SIGNED_EN
    assign lt = $signed(lhs_g) < $signed(rhs_g);
`else
    assign lt = lhs_g < rhs_g;
`endif

    always_comb begin
        p_d = p_q;
        if (gnt_oh != '0) p_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        outs_d       = outs_q;
        outs_valid_d = outs_valid_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                outs_d[i]       = lt;
                outs_valid_d[i] = 1'b1;
            end else if (outs_ready[i]) begin
                outs_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q          <= '0;
            outs_q       <= '0;
            outs_valid_q <= '0;
        end else begin
            p_q          <= p_d;
            outs_q       <= outs_d;
            outs_valid_q <= outs_valid_d;
        end
    end

    assign outs       = outs_q;
    assign outs_valid = outs_valid_q;

endmodule

// File: tb/tb_cmpi_shared_arbiter.sv
// Directed bench for cmpi_shared_arbiter with NUM_REQ=3, DATA_TYPE=8.
module tb_cmpi_shared_arbiter;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] ins_lhs, ins_rhs;
    logic [N-1:0]   ins_valid, ins_ready, outs, outs_valid, outs_ready;

    int checks = 0;
    int errors = 0;

    cmpi_shared_arbiter #(.NUM_REQ(N), .DATA_TYPE(W)) dut (
        .clk(clk), .rst(rst), .ins_lhs(ins_lhs), .ins_rhs(ins_rhs),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .outs(outs),
        .outs_valid(outs_valid), .outs_ready(outs_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
        ins_lhs[i*W +: W] = l;
        ins_rhs[i*W +: W] = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ins_valid = 3'b111; outs_ready = 3'b111;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ins_ready !== 3'b000) begin errors++; $display("FAIL reset_ready c=%0d got=%b exp=000", c, ins_ready); end
            tick();
            checks++;
            if (outs_valid !== 3'b000) begin errors++; $display("FAIL reset_ovalid c=%0d got=%b exp=000", c, outs_valid); end
        end
        checks++;
        if (outs !== 3'b000) begin errors++; $display("FAIL reset_outs got=%b exp=000", outs); end
        rst = 1'b0; ins_valid = 3'b000;
        tick();
    endtask

    task automatic test_single();
        outs_ready = 3'b111; ins_valid = 3'b010; set_op(1, 8'd5, 8'd9);
        #1;
        checks++;
        if (ins_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", ins_ready); end
        tick();
        checks++;
        if (outs_valid !== 3'b010 || outs[1] !== 1'b1) begin errors++; $display("FAIL single_lt got ov=%b o1=%b exp ov=010 o1=1", outs_valid, outs[1]); end
        set_op(1, 8'd9, 8'd9);
        #1;
        checks++;
        if (ins_ready !== 3'b010) begin errors++; $display("FAIL single_refill_ready got=%b exp=010", ins_ready); end
        tick();
        checks++;
        if (outs_valid !== 3'b010 || outs[1] !== 1'b0) begin errors++; $display("FAIL single_eq got ov=%b o1=%b exp ov=010 o1=0", outs_valid, outs[1]); end
        ins_valid = 3'b000;
        tick();
        checks++;
        if (outs_valid !== 3'b000) begin errors++; $display("FAIL single_drain got=%b exp=000", outs_valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_res;
        logic [N-1:0] one_hot;
        int g;
        do_reset();
        set_op(0, 8'd3, 8'd7);      // 1
        set_op(1, 8'd200, 8'd100);  // 0
        set_op(2, 8'd1, 8'd2);      // 1
        exp_res = 3'b101;
        outs_ready = 3'b111; ins_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            g = c % N;
            one_hot = '0;
            one_hot[g] = 1'b1;
            #1;
            checks++;
            if (ins_ready !== one_hot) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, ins_ready, one_hot); end
            tick();
            checks++;
            if (outs_valid !== one_hot || outs[g] !== exp_res[g]) begin
                errors++; $display("FAIL rr_result c=%0d got ov=%b o=%b exp ov=%b o[%0d]=%b", c, outs_valid, outs, one_hot, g, exp_res[g]);
            end
        end
        ins_valid = 3'b000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        outs_ready = 3'b110; ins_valid = 3'b001; set_op(0, 8'd1, 8'd2); set_op(2, 8'd4, 8'd3);
        tick();
        checks++;
        if (outs_valid !== 3'b001 || outs[0] !== 1'b1) begin errors++; $display("FAIL bp_fill got ov=%b o=%b exp ov=001 o0=1", outs_valid, outs); end
        ins_valid = 3'b101;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (ins_ready !== 3'b100) begin errors++; $display("FAIL bp_blocked c=%0d got=%b exp=100", c, ins_ready); end
            tick();
            checks++;
            if (outs_valid !== 3'b101 || outs[0] !== 1'b1 || outs[2] !== 1'b0) begin
                errors++; $display("FAIL bp_hold c=%0d got ov=%b o=%b exp ov=101 o0=1 o2=0", c, outs_valid, outs);
            end
        end
        set_op(0, 8'd2, 8'd1);
        outs_ready = 3'b111;
        #1;
        checks++;
        if (ins_ready !== 3'b001) begin errors++; $display("FAIL bp_refill_ready got=%b exp=001", ins_ready); end
        tick();
        checks++;
        if (outs_valid !== 3'b001 || outs[0] !== 1'b0) begin errors++; $display("FAIL bp_refill got ov=%b o=%b exp ov=001 o0=0", outs_valid, outs); end
        ins_valid = 3'b000;
        tick();
    endtask

    task automatic test_boundary();
        logic [W-1:0] l_tab [3];
        logic [W-1:0] r_tab [3];
        logic         e_tab [3];
        l_tab[0] = 8'hFF; r_tab[0] = 8'h00;
        l_tab[1] = 8'h00; r_tab[1] = 8'hFF;
        l_tab[2] = 8'hAA; r_tab[2] = 8'hAA; e_tab[2] = 1'b0;
`ifdef CMPI_ARB_SIGNED_EN
        e_tab[0] = 1'b1; e_tab[1] = 1'b0;
`else
        e_tab[0] = 1'b0; e_tab[1] = 1'b1;
`endif
        outs_ready = 3'b111;
        for (int t = 0; t < 3; t++) begin
            ins_valid = 3'b001; set_op(0, l_tab[t], r_tab[t]);
            tick();
            checks++;
            if (outs_valid !== 3'b001 || outs[0] !== e_tab[t]) begin
                errors++; $display("FAIL boundary t=%0d got ov=%b o0=%b exp ov=001 o0=%b", t, outs_valid, outs[0], e_tab[t]);
            end
        end
        ins_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        outs_ready = 3'b000; set_op(0, 8'd1, 8'd2); set_op(2, 8'd1, 8'd2);
        ins_valid = 3'b100; tick();   // grant 2, pointer wraps to 0
        ins_valid = 3'b001; tick();   // grant 0, pointer -> 1
        checks++;
        if (outs_valid !== 3'b101 || outs !== 3'b101) begin errors++; $display("FAIL mid_setup got ov=%b o=%b exp ov=101 o=101", outs_valid, outs); end
        rst = 1'b1; ins_valid = 3'b111;
        #1;
        checks++;
        if (ins_ready !== 3'b000) begin errors++; $display("FAIL mid_rst_ready got=%b exp=000", ins_ready); end
        tick();
        checks++;
        if (outs_valid !== 3'b000 || outs !== 3'b000) begin errors++; $display("FAIL mid_rst_clear got ov=%b o=%b exp 000/000", outs_valid, outs); end
        rst = 1'b0; outs_ready = 3'b111;
        #1;
        checks++;
        if (ins_ready !== 3'b001) begin errors++; $display("FAIL mid_ptr_reset got=%b exp=001", ins_ready); end
        ins_valid = 3'b000;
        tick();
    endtask

    initial begin
        rst = 1'b1; ins_lhs = '0; ins_rhs = '0; ins_valid = '0; outs_ready = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
